// File: rtl/digit_scan_pkg.sv
`default_nettype none
// digit_scan_pkg -- shared types and constants for the digit scan controller.  rev 1.0
package digit_scan_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int IDX_W      = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      BLANK = 2'd2
   } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/digit_scan_ctrl_if.sv
`default_nettype none
// digit_scan_ctrl_if -- scan enable, shadow-buffer write handshake and decoder-side outputs.  rev 1.0
interface digit_scan_ctrl_if #(
   parameter int DIGIT_W = 4
);
   import digit_scan_pkg::*;

   logic                          en;
   logic                          wr_valid;
   logic                          wr_ready;
   logic [NUM_DIGITS*DIGIT_W-1:0] wr_data;
   logic                          sel_i0;
   logic                          sel_i1;
   logic [DIGIT_W-1:0]            digit_out;
   logic                          blank;
   logic                          tick;
   logic                          frame_done;

   modport master (
      output en, wr_valid, wr_data,
      input  wr_ready, sel_i0, sel_i1, digit_out, blank, tick, frame_done
   );

   modport slave (
      input  en, wr_valid, wr_data,
      output wr_ready, sel_i0, sel_i1, digit_out, blank, tick, frame_done
   );

endinterface
`default_nettype wire

// File: rtl/digit_scan_prescaler.sv
`default_nettype none
// digit_scan_prescaler -- dwell counter, pulses tick_o on the last cycle of each digit dwell.  rev 1.0
module digit_scan_prescaler #(
   parameter int PRESCALE_DIV = 50000,
   parameter int PRESCALE_W   = 16
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic clr_i,
   input  wire logic run_i,
   output logic      tick_o
);

   localparam logic [PRESCALE_W-1:0] c_last = PRESCALE_W'(PRESCALE_DIV - 1);

   logic [PRESCALE_W-1:0] pcnt_q;
   logic [PRESCALE_W-1:0] pcnt_d;

   assign tick_o = run_i && !clr_i && (pcnt_q == c_last);

   always_comb begin
      pcnt_d = pcnt_q;
      if (clr_i || tick_o) begin
         pcnt_d = '0;
      end else if (run_i) begin
         pcnt_d = pcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// digit_scan_ctrl -- 4-digit scan controller with frame-synchronous shadow buffer.  rev 1.0
// Define SCAN_BLANK_EN to insert BLANK_CYC blanking cycles after every digit dwell.
module digit_scan_ctrl
   import digit_scan_pkg::*;
#(
   parameter int DIGIT_W      = 4,
   parameter int PRESCALE_DIV = 50000,
   parameter int PRESCALE_W   = 16,
   parameter int BLANK_CYC    = 4
) (
   input  wire logic        clk,
   input  wire logic        rst,
   digit_scan_ctrl_if.slave bus
);

   typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

   scan_state_e      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   digits_t          active_q, active_d;
   digits_t          pending_q, pending_d;
   logic             pend_vld_q, pend_vld_d;

   logic w_run;
   logic w_tick;
   logic w_adv;
   logic w_wrap;
   logic w_commit;

   assign w_run = bus.en && (state_q == SCAN);

   digit_scan_prescaler #(
      .PRESCALE_DIV (PRESCALE_DIV),
      .PRESCALE_W   (PRESCALE_W)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (!w_run),
      .run_i  (w_run),
      .tick_o (w_tick)
   );

`ifdef SCAN_BLANK_EN
   localparam int BC_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

   logic [BC_W-1:0] bcnt_q, bcnt_d;

   // The index only advances once the blanking gap has elapsed.
   assign w_adv = bus.en && (state_q == BLANK) && (bcnt_q == BC_W'(BLANK_CYC - 1));
`else
   localparam int c_unused_blank_cyc = BLANK_CYC;

   assign w_adv = w_tick;
`endif

   assign w_wrap   = w_adv && (idx_q == IDX_W'(NUM_DIGITS - 1));
   assign w_commit = pend_vld_q && (w_wrap || (state_q == IDLE));

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      active_d   = active_q;
      pending_d  = pending_q;
      pend_vld_d = pend_vld_q;
`ifdef SCAN_BLANK_EN
      bcnt_d     = '0;
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.en) state_d = SCAN;
         end
         SCAN: begin
            if (w_tick) begin
`ifdef SCAN_BLANK_EN
               state_d = BLANK;
`else
               idx_d = idx_q + 1'b1;
`endif
            end
         end
`ifdef SCAN_BLANK_EN
         BLANK: begin
            bcnt_d = bcnt_q + 1'b1;
            if (w_adv) begin
               idx_d   = idx_q + 1'b1;
               state_d = SCAN;
               bcnt_d  = '0;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      if (bus.wr_valid && !pend_vld_q) begin
         pending_d  = bus.wr_data;
         pend_vld_d = 1'b1;
      end

      // Accept needs !pend_vld_q and commit needs pend_vld_q, so they never collide.
      if (w_commit) begin
         active_d   = pending_q;
         pend_vld_d = 1'b0;
      end

      if (!bus.en) begin
         state_d = IDLE;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         active_q   <= '0;
         pending_q  <= '0;
         pend_vld_q <= 1'b0;
`ifdef SCAN_BLANK_EN
         bcnt_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         active_q   <= active_d;
         pending_q  <= pending_d;
         pend_vld_q <= pend_vld_d;
`ifdef SCAN_BLANK_EN
         bcnt_q     <= bcnt_d;
`endif
      end
   end

   assign bus.sel_i0     = idx_q[0];
   assign bus.sel_i1     = idx_q[1];
   assign bus.digit_out  = active_q[idx_q];
   assign bus.blank      = (state_q != SCAN);
   assign bus.tick       = w_tick;
   assign bus.frame_done = w_wrap;
   assign bus.wr_ready   = !pend_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// tb_digit_scan_ctrl -- directed scoreboard bench for digit_scan_ctrl (DIV=4, BLANK_CYC=2, DIGIT_W=4).  rev 1.0
module tb_digit_scan_ctrl;

   localparam int DIV = 4;
   localparam int BC  = 2;
`ifdef SCAN_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif
   localparam int D      = DIV + (BLANK_ON ? BC : 0);
   localparam int RST_AT = BLANK_ON ? DIV + 1 : 2;

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] dig;
      logic       blank;
      logic       tick;
      logic       fd;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   exp_t sb_q[$];

   digit_scan_ctrl_if #(.DIGIT_W(4)) bus ();

   digit_scan_ctrl #(
      .DIGIT_W      (4),
      .PRESCALE_DIV (DIV),
      .PRESCALE_W   (16),
      .BLANK_CYC    (BC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t obs();
      exp_t o;
      o = {bus.sel_i1, bus.sel_i0, bus.digit_out, bus.blank, bus.tick, bus.frame_done};
      return o;
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   // Expected per-cycle outputs for the first n cycles of a digit's dwell (+ blanking gap).
   task automatic push_digit(input int idx, input logic [15:0] data, input int n);
      exp_t e;
      for (int c = 0; c < n; c++) begin
         e.sel   = idx[1:0];
         e.dig   = data[idx*4 +: 4];
         e.blank = (c >= DIV);
         e.tick  = (c == DIV - 1);
         e.fd    = (idx == 3) && (c == D - 1);
         sb_q.push_back(e);
      end
   endtask

   task automatic push_idle(input logic [15:0] data, input int n);
      exp_t e;
      for (int c = 0; c < n; c++) begin
         e.sel   = 2'b00;
         e.dig   = data[3:0];
         e.blank = 1'b1;
         e.tick  = 1'b0;
         e.fd    = 1'b0;
         sb_q.push_back(e);
      end
   endtask

   task automatic run_check(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: scoreboard empty at step %0d", tag, i);
         end else begin
            exp_t e = sb_q.pop_front();
            chk(tag, 16'(obs()), 16'(e));
         end
      end
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      rst          = 1'b1;
      bus.en       = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;

      // Reset and idle
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs", 16'(obs()), 16'(9'b00_0000_1_0_0));
      chk("reset_wr_ready", 16'(bus.wr_ready), 16'd1);
      rst = 1'b0;
      push_idle(16'h0000, 3);
      run_check(3, "idle");

      // Idle write commits on the following edge
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'h4321;
      @(negedge clk);
      bus.wr_valid = 1'b0;
      chk("idle_wr_ready_low", 16'(bus.wr_ready), 16'd0);
      chk("idle_digit_before_commit", 16'(bus.digit_out), 16'd0);
      @(negedge clk);
      chk("idle_wr_ready_back", 16'(bus.wr_ready), 16'd1);
      chk("idle_digit_committed", 16'(bus.digit_out), 16'd1);

      // Scan one full frame plus the first digit of the next
      bus.en = 1'b1;
      for (int i = 0; i < 4; i++) push_digit(i, 16'h4321, D);
      push_digit(0, 16'h4321, D);
      run_check(5 * D, "scan");

      // Mid-frame write, then a second write that must stall until the frame commit
      for (int i = 1; i < 4; i++) push_digit(i, 16'h4321, D);
      for (int i = 0; i < 4; i++) push_digit(i, 16'h8765, D);
      push_digit(0, 16'hCBA9, D);
      push_digit(1, 16'hCBA9, D);
      push_digit(2, 16'hCBA9, 2);
      run_check(1, "midframe");
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'h8765;
      run_check(1, "midframe");
      chk("wr1_accepted", 16'(bus.wr_ready), 16'd0);
      bus.wr_data = 16'hCBA9;
      run_check(1, "midframe");
      chk("wr2_stalled", 16'(bus.wr_ready), 16'd0);
      run_check(3 * D - 3, "midframe");
      chk("stall_at_frame_done", 16'(bus.wr_ready), 16'd0);
      run_check(1, "midframe");
      chk("ready_after_commit", 16'(bus.wr_ready), 16'd1);
      run_check(1, "midframe");
      chk("wr2_accepted", 16'(bus.wr_ready), 16'd0);
      bus.wr_valid = 1'b0;
      run_check(6 * D, "frames");

      // en drop while idx=2: immediate idle, no frame_done
      bus.en = 1'b0;
      push_idle(16'hCBA9, 3);
      run_check(3, "en_drop");

      // Re-enable restarts at digit 0 with a full dwell
      bus.en = 1'b1;
      push_digit(0, 16'hCBA9, D);
      push_digit(1, 16'hCBA9, D);
      run_check(2 * D, "restart");

      // Asynchronous reset mid-operation discards pending data
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'hFFFF;
      push_digit(2, 16'hCBA9, RST_AT);
      run_check(RST_AT, "pre_rst");
      #2;
      rst    = 1'b1;
      bus.en = 1'b0;
      #1;
      chk("async_rst_outputs", 16'(obs()), 16'(9'b00_0000_1_0_0));
      chk("async_rst_wr_ready", 16'(bus.wr_ready), 16'd1);
      bus.wr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      push_idle(16'h0000, 2);
      run_check(2, "post_rst_idle");

      chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Sequential stage directly upstream of the 2-to-4 decoder.
- Time-multiplexes four display digits. Generates the 2-bit scan index that drives the decoder inputs (i0/i1), and presents the matching digit value on digit_out.
- Digit values are written through a valid/ready interface into a shadow buffer. The shadow buffer is committed only on frame boundaries, so a partial update is never displayed.

Parameters:
- DIGIT_W, 4: bits per digit value.
- PRESCALE_DIV, 50000: clk cycles per digit dwell. Legal range ≥2.
- PRESCALE_W, 16: prescaler counter width. Must satisfy 2**PRESCALE_W ≥ PRESCALE_DIV.
- BLANK_CYC, 4: blanking cycles between digits. Used only with SCAN_BLANK_EN. Legal range ≥1.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- en, in, 1: scan enable.
- wr_valid, in, 1: write request.
- wr_ready, out, 1: shadow buffer free.
- wr_data, in, 4*DIGIT_W: digit 0 in LSBs … digit 3 in MSBs.
- sel_i0, out, 1: scan index bit 0, to decoder i0.
- sel_i1, out, 1: scan index bit 1, to decoder i1.
- digit_out, out, DIGIT_W: value of the currently selected digit.
- blank, out, 1: 1 = drivers must be off.
- tick, out, 1: one-cycle pulse at end of each digit dwell.
- frame_done, out, 1: one-cycle pulse when the index wraps 3→0.

Behaviour:
- Reset values:
  - state=IDLE, idx=0, pcnt=0.
  - active=0, pending=0, pending_valid=0.
  - Outputs: sel=00, digit_out=0, blank=1, tick=0, frame_done=0, wr_ready=1.
- Output derivation:
  - sel_i1/sel_i0 = idx[1:0], decoded from registers only.
  - digit_out = active[idx*DIGIT_W +: DIGIT_W].
- State machine:
  - IDLE: blank=1, idx=0, pcnt=0. en=1 → SCAN on next edge.
  - SCAN: blank=0. pcnt counts 0..PRESCALE_DIV-1. tick=1 when pcnt==PRESCALE_DIV-1; pcnt then wraps to 0.
    - On tick without the optional feature: idx←idx+1 (mod 4) and state stays SCAN.
  - en=0 in any state → IDLE on next edge, with idx and pcnt cleared. This abandons the frame mid-digit; frame_done is not pulsed.
- Frame boundary:
  - On the idx 3→0 increment: frame_done=1 for that cycle.
  - If pending_valid=1 at the boundary: active←pending and pending_valid←0 on the same edge.
- Write handshake:
  - wr_ready = !pending_valid.
  - Accept when wr_valid && wr_ready: pending←wr_data, pending_valid←1.
  - A second write stalls (wr_ready=0) until commit. wr_valid held high with wr_ready low has no effect.
  - Accept and commit never coincide, because commit requires pending_valid=1, which forces wr_ready=0.
- In IDLE, a pending write commits on the next edge. An idle display always holds the latest data.
- Latency:
  - Accepted write to visible digit: ≤ one full frame (4×dwell) while scanning; 1 cycle in IDLE.
  - en rise to first non-blank cycle: 1 cycle.
- Asynchronous rst mid-operation: immediate return to all reset values. Pending data is discarded.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- With the macro defined:
  - Added state BLANK. On tick in SCAN → BLANK, with blank=1 for BLANK_CYC cycles (sel and digit_out unchanged).
  - Then idx←idx+1 and state returns to SCAN with pcnt=0.
  - Frame commit and frame_done occur on the increment that leaves BLANK.
  - en=0 in BLANK → IDLE on next edge.
- Without the macro: no BLANK state, and blank=0 throughout SCAN.

Decomposition:
- Package digit_scan_pkg contains:
  - the state enum typedef (IDLE, SCAN, BLANK);
  - localparam NUM_DIGITS=4;
  - localparam IDX_W=2.
- One sub-module, digit_scan_prescaler: holds pcnt, with inputs clr/run and output tick. The FSM, idx and buffers stay in the top.

Test Plan:
All scenarios use PRESCALE_DIV=4, BLANK_CYC=2, DIGIT_W=4.
- Reset/idle: rst=1, then 0, with en=0 → sel=00, digit_out=0, blank=1, wr_ready=1; tick never pulses.
- Idle write: write wr_data=16'h4321 with en=0 → wr_ready drops for 1 cycle, active=16'h4321 next edge, digit_out=1.
- Scan sequence, macro off: en=1 → sel visits 00,01,10,11,00 with 4 cycles each; digit_out visits 1,2,3,4,1; frame_done pulses once, on the wrap.
- Mid-frame write: while scanning digit 1, write 16'h8765, then attempt a second write → wr_ready stays 0 until frame_done. digit_out shows 3,4 (old) before switching to 5 on digit 0; the second write is accepted the cycle after commit.
- en drop mid-frame: deassert en while idx=2 → next edge idx=0, blank=1, no frame_done pulse. Re-enable → scan restarts at digit 0 with full dwell.
- SCAN_BLANK_EN: each digit shows 4 cycles non-blank then 2 cycles blank=1 before sel advances; frame period = 24 cycles. An asynchronous rst asserted during BLANK clears outputs immediately.
